// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared constants and types for the instruction-memory responder.
//   NOP        : word returned for bubbles and faulting fetches (addi x0,x0,0)
//   RESET_PC   : the fetch unit's PC while it is held in / leaving reset
//   state_e    : responder FSM states
//   fault_reason_e : fault cause encoding, not yet driven onto any port
//   addr_fault : true when a byte address is misaligned or beyond the array
// -----------------------------------------------------------------------------
package imem_pkg;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFFC;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        FR_NONE     = 2'd0,
        FR_MISALIGN = 2'd1,
        FR_RANGE    = 2'd2
    } fault_reason_e;

    // Word index is compared at full 32-bit width so addresses far above
    // the array cannot alias back into range.
    function automatic logic addr_fault(input logic [31:0] a, input int unsigned depth);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/imem_array.sv
// -----------------------------------------------------------------------------
// imem_array
// DEPTH_WORDS x 32 storage, one synchronous write port and one registered
// read port. A read and a write to the same word on the same edge return the
// old contents (read-before-write). The array has no reset.
//   clk        : clock
//   we_i       : write enable
//   waddr_i    : write word address
//   wdata_i    : write data
//   rd_en_i    : read enable; rdata_o updates only on enabled edges
//   raddr_i    : read word address
//   rdata_o    : registered read data
// -----------------------------------------------------------------------------
module imem_array #(
    parameter  int DEPTH_WORDS = 4096,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (rd_en_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_resp.sv
// -----------------------------------------------------------------------------
// imem_resp
// Instruction-memory responder for the fetch unit. Samples pc, returns the
// addressed word LATENCY cycles later, and raises stop so pc is held while an
// access is in flight or decode back-pressures through hold.
//   clk, rst     : clock, asynchronous active-high reset
//   pc           : fetch address
//   hold         : decode stall; freezes instr/instr_valid/fault
//   prog_we/addr/wdata : write-only program port into the array
//   instr        : fetched word (NOP for bubbles and faults)
//   instr_valid  : instr is a real instruction
//   fault        : access fault, qualified by instr_valid
//   stop         : fetch unit must keep pc unchanged this cycle
// -----------------------------------------------------------------------------
module imem_resp
    import imem_pkg::*;
#(
    parameter  int DEPTH_WORDS = 4096,
    parameter  int LATENCY     = 1,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   pc,
    input  logic          hold,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_wdata,
    output logic [31:0]   instr,
    output logic          instr_valid,
    output logic          fault,
    output logic          stop
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    // instr is sourced from the array's read register when the last
    // completion was a good fetch, otherwise it is NOP.
    logic        src_mem_q, src_mem_d;

    logic        complete;
    logic        rd_en;
    logic [31:0] addr;
    logic [31:0] rd_data;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_pc_d  = req_pc_q;
        valid_d   = valid_q;
        fault_d   = fault_q;
        src_mem_d = src_mem_q;
        complete  = 1'b0;
        rd_en     = 1'b0;
        addr      = req_pc_q;

        if (LATENCY == 1) begin
            // Single-cycle: request and completion share the edge.
            addr     = pc;
            complete = !hold;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!hold) begin
                        state_d  = BUSY;
                        cnt_d    = CNT_INIT;
                        req_pc_d = pc;
                    end
                end
                BUSY: begin
                    if (cnt_q > 4'd1) begin
                        cnt_d = cnt_q - 4'd1;
                    end else if (!hold) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                        cnt_d    = 4'd0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end

        if (complete) begin
            if (addr == RESET_PC) begin
                // Fetch unit still at its reset PC: emit a bubble.
                valid_d   = 1'b0;
                fault_d   = 1'b0;
                src_mem_d = 1'b0;
            end else if (addr_fault(addr, DEPTH_WORDS)) begin
                valid_d   = 1'b1;
                fault_d   = 1'b1;
                src_mem_d = 1'b0;
            end else begin
                valid_d   = 1'b1;
                fault_d   = 1'b0;
                src_mem_d = 1'b1;
                rd_en     = 1'b1;
            end
        end else if (!hold) begin
            valid_d = 1'b0;
            fault_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            req_pc_q  <= 32'd0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            src_mem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_pc_q  <= req_pc_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
            src_mem_q <= src_mem_d;
        end
    end

    imem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .we_i    (prog_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_wdata),
        .rd_en_i (rd_en),
        .raddr_i (addr[AW+1:2]),
        .rdata_o (rd_data)
    );

    assign instr       = src_mem_q ? rd_data : NOP;
    assign instr_valid = valid_q;
    assign fault       = fault_q;
    // Only the final BUSY cycle lets pc advance; it moves on the edge the
    // data lands.
    assign stop        = hold | ((LATENCY > 1) && !(state_q == BUSY && cnt_q == 4'd1));

endmodule

// File: tb/tb_imem_resp.sv
module tb_imem_resp;

    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_wdata;

    logic [31:0] pc1, pc3, pc4;
    logic        hold1, hold3, hold4;
    logic [31:0] instr1, instr3, instr4;
    logic        valid1, valid3, valid4;
    logic        fault1, fault3, fault4;
    logic        stop1, stop3, stop4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .pc(pc1), .hold(hold1),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .instr(instr1), .instr_valid(valid1), .fault(fault1), .stop(stop1)
    );

    imem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst), .pc(pc3), .hold(hold3),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .instr(instr3), .instr_valid(valid3), .fault(fault3), .stop(stop3)
    );

    imem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) u_lat4 (
        .clk(clk), .rst(rst), .pc(pc4), .hold(hold4),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .instr(instr4), .instr_valid(valid4), .fault(fault4), .stop(stop4)
    );

    typedef struct {
        logic [31:0] pc;
        logic        hold;
        logic [31:0] instr;
        logic        valid;
        logic        fault;
        logic        stop;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [AW-1:0] a, input logic [31:0] d);
        prog_we    = 1'b1;
        prog_addr  = a;
        prog_wdata = d;
        tick();
        prog_we    = 1'b0;
    endtask

    initial begin
        int k;

        // LATENCY=1 table: outputs expected in the same cycle as the row's
        // inputs are the result of the previous row's pc.
        vecs[0]  = '{32'hFFFF_FFFC, 1'b0, 32'h13, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'h0000_0000, 1'b0, 32'h13, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{32'h0000_0004, 1'b0, 32'h11, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{32'h0000_0008, 1'b0, 32'h22, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{32'h0000_0000, 1'b1, 32'h33, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{32'h0000_0000, 1'b1, 32'h33, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{32'h0000_0002, 1'b0, 32'h33, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{32'h0000_0100, 1'b0, 32'h13, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{32'h0000_0004, 1'b0, 32'h13, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{32'hFFFF_FFFC, 1'b0, 32'h22, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{32'h0000_0008, 1'b0, 32'h13, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{32'h0000_0008, 1'b0, 32'h33, 1'b1, 1'b0, 1'b0};

        rst        = 1'b1;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_wdata = 32'd0;
        pc1 = 32'hFFFF_FFFC; pc3 = 32'hFFFF_FFFC; pc4 = 32'hFFFF_FFFC;
        hold1 = 1'b0; hold3 = 1'b1; hold4 = 1'b1;
        #2;

        chk("rst_instr1", instr1, 32'h13);
        chk("rst_valid1", {31'd0, valid1}, 32'd0);
        chk("rst_fault1", {31'd0, fault1}, 32'd0);
        chk("rst_stop1", {31'd0, stop1}, 32'd0);
        chk("rst_stop3", {31'd0, stop3}, 32'd1);

        prog(6'd0, 32'h11);
        prog(6'd1, 32'h22);
        prog(6'd2, 32'h33);
        prog(6'd5, 32'h55);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            pc1   = vecs[i].pc;
            hold1 = vecs[i].hold;
            #1;
            chk($sformatf("l1_instr[%0d]", i), instr1, vecs[i].instr);
            chk($sformatf("l1_valid[%0d]", i), {31'd0, valid1}, {31'd0, vecs[i].valid});
            chk($sformatf("l1_fault[%0d]", i), {31'd0, fault1}, {31'd0, vecs[i].fault});
            chk($sformatf("l1_stop[%0d]", i), {31'd0, stop1}, {31'd0, vecs[i].stop});
            tick();
        end
        pc1 = 32'hFFFF_FFFC;

        prog(6'd1, 32'hAB);

        // LATENCY=3: plain access, then an access with hold at cnt==1.
        pc3 = 32'h4; hold3 = 1'b0; #1;
        chk("l3_stop_t0", {31'd0, stop3}, 32'd1);
        tick();
        chk("l3_stop_t1", {31'd0, stop3}, 32'd1);
        chk("l3_valid_t1", {31'd0, valid3}, 32'd0);
        tick();
        chk("l3_stop_t2", {31'd0, stop3}, 32'd0);
        chk("l3_valid_t2", {31'd0, valid3}, 32'd0);
        tick();
        chk("l3_instr_t3", instr3, 32'hAB);
        chk("l3_valid_t3", {31'd0, valid3}, 32'd1);
        chk("l3_fault_t3", {31'd0, fault3}, 32'd0);
        pc3 = 32'h8; #1;
        chk("l3_stop_t3", {31'd0, stop3}, 32'd1);
        tick();
        chk("l3_valid_t4", {31'd0, valid3}, 32'd0);
        chk("l3_instr_t4", instr3, 32'hAB);
        tick();
        chk("l3_stop_t5_nohold", {31'd0, stop3}, 32'd0);
        hold3 = 1'b1; #1;
        chk("l3_stop_t5_hold", {31'd0, stop3}, 32'd1);
        tick();
        chk("l3_stop_t6", {31'd0, stop3}, 32'd1);
        chk("l3_valid_t6", {31'd0, valid3}, 32'd0);
        tick();
        hold3 = 1'b0; #1;
        chk("l3_stop_t7", {31'd0, stop3}, 32'd0);
        chk("l3_valid_t7", {31'd0, valid3}, 32'd0);
        tick();
        chk("l3_instr_t8", instr3, 32'h33);
        chk("l3_valid_t8", {31'd0, valid3}, 32'd1);
        hold3 = 1'b1;

        // LATENCY=4: one access, then reset during the next at cnt==1.
        pc4 = 32'h4; hold4 = 1'b0;
        tick(); tick(); tick(); tick();
        chk("l4_instr_t4", instr4, 32'hAB);
        chk("l4_valid_t4", {31'd0, valid4}, 32'd1);
        chk("l4_fault_t4", {31'd0, fault4}, 32'd0);
        pc4 = 32'h8;
        tick();
        chk("l4_valid_t5", {31'd0, valid4}, 32'd0);
        chk("l4_instr_t5", instr4, 32'hAB);
        tick(); tick();
        chk("l4_stop_cnt1", {31'd0, stop4}, 32'd0);
        rst = 1'b1; #1;
        chk("l4_rst_instr", instr4, 32'h13);
        chk("l4_rst_valid", {31'd0, valid4}, 32'd0);
        chk("l4_rst_stop", {31'd0, stop4}, 32'd1);
        tick();
        rst = 1'b0;
        pc4 = 32'hFFFF_FFFC;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("l4_bubble[%0d]", i), {31'd0, valid4}, 32'd0);
            tick();
        end
        k = 0;
        while (stop4 !== 1'b0 && k < 10) begin
            tick();
            k++;
        end
        chk("l4_stop_wait", {31'd0, stop4}, 32'd0);
        tick();
        pc4 = 32'h0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("l4_nopulse[%0d]", i), {31'd0, valid4}, 32'd0);
            tick();
        end
        chk("l4_new_instr", instr4, 32'h11);
        chk("l4_new_valid", {31'd0, valid4}, 32'd1);
        hold4 = 1'b1;

        // Write colliding with the completion read returns old data.
        pc1 = 32'h14; hold1 = 1'b0;
        prog(6'd5, 32'hDEAD);
        chk("coll_old", instr1, 32'h55);
        chk("coll_old_valid", {31'd0, valid1}, 32'd1);
        tick();
        chk("coll_new", instr1, 32'hDEAD);
        chk("coll_new_valid", {31'd0, valid1}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
